// File: rtl/b9_arb.sv
// b9_arb: round-robin request arbiter with a handshake-held grant and an
// optional idle hold window after every completed grant.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req          per-channel level request
//   mask         per-channel disable (1 = excluded from arbitration)
//   hold_cycles  idle cycles inserted after each completed grant
//   gnt_rdy      consumer accepts the offered grant
//   lock         burst request, sampled at handshake (B9_ARB_LOCK_EN only)
//   gnt          registered one-hot grant, zero when nothing is offered
//   gnt_idx      registered binary index of the granted channel
//   gnt_vld      registered grant-offered flag
//   busy         registered, high whenever the FSM is outside IDLE
//
// Build option: define B9_ARB_LOCK_EN to let a handshake with lock=1 keep
// the current channel granted while its request stays high.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant offered; arbitrate eligible requests from ptr
// GRANT | grant offered and held stable until gnt_vld & gnt_rdy
// HOLD  | post-grant idle window, hold counter counts down to zero
module b9_arb #(
  parameter int N_CH   = 4,
  parameter int HOLD_W = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH-1:0]   mask,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              gnt_rdy,
  input  logic              lock,
  output logic [N_CH-1:0]   gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_vld,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_HOLD} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                vld_q, vld_d;
  logic                busy_q, busy_d;

  logic [N_CH-1:0]     elig;
  logic                hi_found, lo_found;
  logic [IDX_W-1:0]    hi_idx, lo_idx, sel_idx;
  logic [IDX_W-1:0]    ptr_nxt;
  logic                lock_keep;

  assign elig = req & ~mask;

  // Round-robin pick: lowest eligible channel at or above ptr, otherwise
  // wrap to the lowest eligible channel overall. Descending scan so the
  // last write wins with the lowest index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (elig[c]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(c);
        if (c >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(c);
        end
      end
    end
    sel_idx = hi_found ? hi_idx : lo_idx;
  end

  assign ptr_nxt = (idx_q == IDX_W'(N_CH - 1)) ? '0 : idx_q + 1'b1;

`ifdef B9_ARB_LOCK_EN
  assign lock_keep = lock & req[idx_q];
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign lock_keep   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        idx_d = '0;
        vld_d = 1'b0;
        if (lo_found) begin
          gnt_d   = {{(N_CH-1){1'b0}}, 1'b1} << sel_idx;
          idx_d   = sel_idx;
          vld_d   = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (vld_q && gnt_rdy && !lock_keep) begin
          ptr_d = ptr_nxt;
          gnt_d = '0;
          idx_d = '0;
          vld_d = 1'b0;
          if (hold_cycles == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = hold_cycles;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // cnt_q==1 is the last hold cycle: the count reaches zero as IDLE
        // is entered, so HOLD spans exactly hold_cycles cycles.
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        if (cnt_q <= HOLD_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_b9_arb.sv
// Directed bench for b9_arb (N_CH=4). Inputs change 1ns after the rising
// edge; outputs are sampled at the same point, so each tick() shows the
// registered result of the edge just taken.
module tb_b9_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] mask;
  logic [3:0] hold_cycles;
  logic       gnt_rdy;
  logic       lock;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       busy;

  int checks = 0;
  int errors = 0;

  b9_arb #(.N_CH(4), .HOLD_W(4), .IDX_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .mask        (mask),
    .hold_cycles (hold_cycles),
    .gnt_rdy     (gnt_rdy),
    .lock        (lock),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_vld     (gnt_vld),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_idx,
                           input logic e_vld, input logic e_busy);
    check({tag, "/gnt"},  32'(gnt),     32'(e_gnt));
    check({tag, "/idx"},  32'(gnt_idx), 32'(e_idx));
    check({tag, "/vld"},  32'(gnt_vld), 32'(e_vld));
    check({tag, "/busy"}, 32'(busy),    32'(e_busy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] lk_gnt [4];
  logic [1:0] lk_idx [4];
  logic       lk_vld [4];

  initial begin
    rst_n = 1'b0; req = '0; mask = '0; hold_cycles = '0; gnt_rdy = 1'b0; lock = 1'b0;
    tick(); tick();
    check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Nothing eligible: stay idle, ptr untouched.
    req = 4'b1111; mask = 4'b1111; gnt_rdy = 1'b1;
    tick(); check_out("all_masked0", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); check_out("all_masked1", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Alternating 1010 pattern.
    req = 4'b1010; mask = 4'b0000;
    tick(); check_out("rr_g1", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick(); check_out("rr_i1", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); check_out("rr_g3", 4'b1000, 2'd3, 1'b1, 1'b1);
    tick(); check_out("rr_i2", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); check_out("rr_g1b", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick(); check_out("rr_i3", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Masked channels 0 and 2 never win; ptr is 2 here.
    req = 4'b1111; mask = 4'b0101;
    tick(); check_out("mk_g3", 4'b1000, 2'd3, 1'b1, 1'b1);
    tick(); check_out("mk_i1", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); check_out("mk_g1", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick(); check_out("mk_i2", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); check_out("mk_g3b", 4'b1000, 2'd3, 1'b1, 1'b1);
    req = 4'b0000; mask = 4'b0000;
    tick(); check_out("mk_i3", 4'b0000, 2'd0, 1'b0, 1'b0);

    // ptr = 0. Grant ch2, stall 5 cycles; req drops and mask changes mid-stall.
    req = 4'b0100; gnt_rdy = 1'b0;
    tick(); check_out("st_g2", 4'b0100, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) req = 4'b0000;
      if (i == 2) mask = 4'b0100;
      tick(); check_out($sformatf("stall%0d", i), 4'b0100, 2'd2, 1'b1, 1'b1);
    end
    gnt_rdy = 1'b1;
    tick(); check_out("st_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // ptr = 3. Hold window of 3 cycles after a ch0 grant.
    mask = 4'b0000; req = 4'b0011; hold_cycles = 4'd3;
    tick(); check_out("hd_g0", 4'b0001, 2'd0, 1'b1, 1'b1);
    tick(); check_out("hd_h1", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick(); check_out("hd_h2", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick(); check_out("hd_h3", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick(); check_out("hd_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); check_out("hd_g1", 4'b0010, 2'd1, 1'b1, 1'b1);

    // Handshake on ch1 (ptr -> 2), then reset in the middle of HOLD.
    tick(); check_out("rh_h1", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick(); check_out("rh_h2", 4'b0000, 2'd0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    check_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1010; hold_cycles = 4'd0;
    tick();
    rst_n = 1'b1;
    tick(); check_out("pr_g1", 4'b0010, 2'd1, 1'b1, 1'b1);
    req = 4'b1000;
    tick(); check_out("pr_i1", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); check_out("pr_g3", 4'b1000, 2'd3, 1'b1, 1'b1);
    req = 4'b1010;
    tick(); check_out("pr_i2", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); check_out("pr_g1b", 4'b0010, 2'd1, 1'b1, 1'b1);

    // Four consecutive handshakes on ch1 with lock high.
`ifdef B9_ARB_LOCK_EN
    lk_gnt = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
    lk_idx = '{2'd1, 2'd1, 2'd1, 2'd1};
    lk_vld = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    lk_gnt = '{4'b0000, 4'b1000, 4'b0000, 4'b0010};
    lk_idx = '{2'd0, 2'd3, 2'd0, 2'd1};
    lk_vld = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); check_out($sformatf("lock%0d", i), lk_gnt[i], lk_idx[i], lk_vld[i], lk_vld[i]);
    end
    lock = 1'b0; req = 4'b0000;
    tick(); check_out("end_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
